if_fetch_queue: RTL
===================

Name: if_fetch_queue

Overview:
- Decoupling buffer between the fetch stage (PC register + instruction memory) and the IF/ID decode boundary.
- Captures each fetched {PC, Instr} pair into a small circular FIFO.
- Presents pairs in order to decode with valid/ready handshakes on both sides.
- A single-cycle flush discards all buffered fetches on branch/jump redirect, so fetch can run ahead of decode stalls.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- PTR_W, 2, read/write pointer width; must equal log2(DEPTH).
- CNT_W, 3, occupancy counter width; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  fetch stage presents a pair this cycle.
- in_ready  output  1  queue accepts a pair this cycle.
- in_pc  input  32  PC of fetched instruction.
- in_instr  input  32  fetched instruction word.
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode consumes head this cycle.
- out_pc  output  32  PC of head entry.
- out_instr  output  32  instruction of head entry.
- flush  input  1  synchronous discard of all entries (redirect).
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, in_ready=1, out_pc=32'h00000000, out_instr=32'h00000000.
  - Storage contents need not be cleared.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). Registered-state only; no combinational path from out_ready. A full queue refuses a push even when a pop happens in the same cycle.
- out_valid = (count != 0).
- out_pc/out_instr = storage[rd_ptr] when out_valid=1; forced to 32'h00000000 when out_valid=0.
- Latency: a pair pushed at edge N is visible on out_* after edge N (one-cycle fall-through, no bypass unless the optional feature is compiled in).
- On push: storage[wr_ptr] <= {in_pc, in_instr}; wr_ptr <= wr_ptr+1, wrapping DEPTH-1 -> 0 through natural PTR_W overflow.
- On pop: rd_ptr <= rd_ptr+1, same wrap rule.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Ordering is strict FIFO; no reordering or duplication.
- flush=1 (sampled at clock edge) has highest priority:
  - wr_ptr, rd_ptr and count all go to 0.
  - A push in the same cycle is dropped.
  - A pop in the same cycle counts as completed for decode, but the queue is cleared regardless.
  - out_valid=0 from the following cycle.
  - in_ready=1 from the following cycle.
- Flush while empty: no effect beyond pointer reset.
- Reset asserted mid-operation: all state is cleared immediately (asynchronously); in-flight handshakes are void. Deassertion is synchronised externally.
- The queue never checks in_pc alignment or sequence; it carries data opaquely.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- When defined:
  - If count==0 and flush==0, out_valid=in_valid, out_pc=in_pc, out_instr=in_instr combinationally.
  - If out_ready=1 in that cycle, the pair is consumed directly: no write, pointers and count unchanged.
  - If out_ready=0, the pair is stored normally.
  - Latency for an empty queue becomes 0 cycles.
- When undefined: the behaviour above holds, with 1-cycle minimum latency.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release -> count=0, out_valid=0, in_ready=1, out_pc=0.
- Fill to full: 4 pushes (PC 0x3000, 0x3004, 0x3008, 0x300C), out_ready=0 -> count=4, in_ready=0. A 5th push (0x3010) is refused. Then out_ready=1 for 4 cycles -> out_pc 0x3000..0x300C in order, count returns to 0.
- Simultaneous push/pop at count=2: -> count stays 2, order preserved. Run 10 cycles continuous to exercise pointer wrap -> no loss or duplication of PCs 0x3000..0x3024.
- Flush with push and pop: at count=3, assert flush with in_valid=1 (PC 0x4000) and out_ready=1 -> next cycle count=0, out_valid=0, and 0x4000 never appears at the output.
- Async reset mid-stream: at count=2, drive reset=0 between clock edges -> out_valid=0 and count=0 before the next edge.
- Bypass (with FETCH_QUEUE_BYPASS_EN): empty queue, in_valid=1 (PC 0x3000, instr 0x24010001), out_ready=1 -> same-cycle out_valid=1, out_pc=0x3000; count stays 0.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Fetch-to-decode decoupling FIFO holding {PC, instr} pairs, with single-cycle flush on redirect.
// Optional same-cycle bypass for an empty queue when FETCH_QUEUE_BYPASS_EN is defined.
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop, bypass_hit, empty;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    in_ready   = (count_q != CNT_W'(DEPTH));
    out_valid  = !empty;
    out_pc     = empty ? 32'h0 : head.pc;
    out_instr  = empty ? 32'h0 : head.instr;
    bypass_hit = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue: present the incoming pair directly; only store it if decode stalls.
    if (empty && !flush) begin
      out_valid  = in_valid;
      out_pc     = in_valid ? in_pc    : 32'h0;
      out_instr  = in_valid ? in_instr : 32'h0;
      bypass_hit = in_valid & out_ready;
    end
`endif
    push = in_valid & in_ready & ~bypass_hit;
    pop  = out_valid & out_ready & ~bypass_hit;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    // Redirect wins over everything: any same-cycle push is dropped.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; out_* are masked while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= '{pc: in_pc, instr: in_instr};
  end

endmodule
